// File: rtl/operand_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module : operand_fetch_pkg
// Brief  : Shared widths, register-file constants and slot state encoding
// Rev    : 1.0 - initial release
// ============================================================================
package operand_fetch_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int PAYLOAD_W  = 32;

    localparam logic [REG_ADDR_W-1:0] c_X0_IDX = '0;
    localparam logic c_EN_ON  = 1'b1;
    localparam logic c_EN_OFF = 1'b0;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // An instruction owns a scoreboard entry only if it really writes a non-x0 register.
    function automatic logic writes_reg(input logic we, input logic [REG_ADDR_W-1:0] rd);
        return (we == c_EN_ON) && (rd != c_X0_IDX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/operand_fetch_if.sv
`default_nettype none
// ============================================================================
// Module : operand_fetch_if
// Brief  : Decode, register-file and execute signals seen by operand_fetch
// Rev    : 1.0 - initial release
// ============================================================================
interface operand_fetch_if #(
    parameter int XLEN       = operand_fetch_pkg::XLEN,
    parameter int REG_ADDR_W = operand_fetch_pkg::REG_ADDR_W,
    parameter int PAYLOAD_W  = operand_fetch_pkg::PAYLOAD_W
);
    logic                  rdy;
    logic                  flush;
    logic                  id_valid;
    logic                  id_ready;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_rd_we;
    logic [XLEN-1:0]       id_pc;
    logic [XLEN-1:0]       id_imm;
    logic [PAYLOAD_W-1:0]  id_payload;
    logic                  re1;
    logic                  re2;
    logic [REG_ADDR_W-1:0] raddr1;
    logic [REG_ADDR_W-1:0] raddr2;
    logic [XLEN-1:0]       rdata1;
    logic [XLEN-1:0]       rdata2;
    logic                  wb_we;
    logic [REG_ADDR_W-1:0] wb_waddr;
    logic                  ex_valid;
    logic                  ex_ready;
    logic [XLEN-1:0]       ex_op1;
    logic [XLEN-1:0]       ex_op2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_rd_we;
    logic [PAYLOAD_W-1:0]  ex_payload;

    modport master (
        input  rdy, flush,
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  id_rd, id_rd_we, id_pc, id_imm, id_payload,
        output id_ready,
        output re1, re2, raddr1, raddr2,
        input  rdata1, rdata2,
        input  wb_we, wb_waddr,
        output ex_valid, ex_op1, ex_op2, ex_rd, ex_rd_we, ex_payload,
        input  ex_ready
    );

    modport slave (
        output rdy, flush,
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output id_rd, id_rd_we, id_pc, id_imm, id_payload,
        input  id_ready,
        input  re1, re2, raddr1, raddr2,
        output rdata1, rdata2,
        output wb_we, wb_waddr,
        input  ex_valid, ex_op1, ex_op2, ex_rd, ex_rd_we, ex_payload,
        output ex_ready
    );
endinterface
`default_nettype wire

// File: rtl/operand_fetch_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : operand_scoreboard
// Brief  : Per-register busy bits with writeback/flush clear and accept set
// Rev    : 1.0 - initial release
// ============================================================================
module operand_scoreboard
    import operand_fetch_pkg::*;
#(
    parameter int REG_ADDR_W = operand_fetch_pkg::REG_ADDR_W
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_en,
    input  wire logic                  i_set,
    input  wire logic [REG_ADDR_W-1:0] i_set_idx,
    input  wire logic                  i_clr_wb,
    input  wire logic [REG_ADDR_W-1:0] i_clr_wb_idx,
    input  wire logic                  i_clr_fl,
    input  wire logic [REG_ADDR_W-1:0] i_clr_fl_idx,
    input  wire logic [REG_ADDR_W-1:0] i_idx_a,
    input  wire logic [REG_ADDR_W-1:0] i_idx_b,
    input  wire logic [REG_ADDR_W-1:0] i_idx_c,
    output logic                       o_eff_a,
    output logic                       o_eff_b,
    output logic                       o_eff_c
);
    localparam int NUM_REGS = 1 << REG_ADDR_W;

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] w_clr_vec;
    logic [NUM_REGS-1:0] w_eff;

    always_comb begin
        w_clr_vec = '0;
        if (i_clr_wb) begin
            w_clr_vec[i_clr_wb_idx] = 1'b1;
        end
        // A register retiring this cycle already reads correctly through the RF bypass.
        w_eff  = busy_q & ~w_clr_vec;
        busy_d = busy_q;
        if (i_en) begin
            busy_d = w_eff;
            if (i_clr_fl) begin
                busy_d[i_clr_fl_idx] = 1'b0;
            end
            if (i_set) begin
                busy_d[i_set_idx] = 1'b1;
            end
            busy_d[c_X0_IDX] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign o_eff_a = w_eff[i_idx_a];
    assign o_eff_b = w_eff[i_idx_b];
    assign o_eff_c = w_eff[i_idx_c];

endmodule
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module : operand_fetch
// Brief  : RF read-port initiator with RAW/WAW scoreboard and one-entry slot
// Rev    : 1.0 - initial release
// ============================================================================
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int XLEN       = operand_fetch_pkg::XLEN,
    parameter int REG_ADDR_W = operand_fetch_pkg::REG_ADDR_W,
    parameter int PAYLOAD_W  = operand_fetch_pkg::PAYLOAD_W
) (
    input wire logic        clk,
    input wire logic        rst,
    operand_fetch_if.master bus
);
    slot_state_t           state_q,   state_d;
    logic [XLEN-1:0]       op1_q,     op1_d;
    logic [XLEN-1:0]       op2_q,     op2_d;
    logic [REG_ADDR_W-1:0] rd_q,      rd_d;
    logic                  rd_we_q,   rd_we_d;
    logic [PAYLOAD_W-1:0]  payload_q, payload_d;

    logic w_run;
    logic w_eff_rs1;
    logic w_eff_rs2;
    logic w_eff_rd;
    logic w_hz;
    logic w_slot_free;
    logic w_id_ready;
    logic w_accept;
    logic w_flush;
    logic w_kill_clr;

    assign w_run = (bus.rdy == c_EN_ON);

    operand_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .i_en         (w_run),
        .i_set        (w_accept && writes_reg(bus.id_rd_we, bus.id_rd)),
        .i_set_idx    (bus.id_rd),
        .i_clr_wb     (bus.wb_we == c_EN_ON),
        .i_clr_wb_idx (bus.wb_waddr),
        .i_clr_fl     (w_kill_clr),
        .i_clr_fl_idx (rd_q),
        .i_idx_a      (bus.id_rs1),
        .i_idx_b      (bus.id_rs2),
        .i_idx_c      (bus.id_rd),
        .o_eff_a      (w_eff_rs1),
        .o_eff_b      (w_eff_rs2),
        .o_eff_c      (w_eff_rd)
    );

    assign w_hz = (bus.id_use_rs1 && w_eff_rs1)
               || (bus.id_use_rs2 && w_eff_rs2)
               || (writes_reg(bus.id_rd_we, bus.id_rd) && w_eff_rd);

    assign w_slot_free = (state_q == SLOT_EMPTY) || bus.ex_ready;
    assign w_id_ready  = w_run && !w_hz && w_slot_free;
    // Flush leaves id_ready visible but suppresses the accept itself.
    assign w_accept    = bus.id_valid && w_id_ready && !bus.flush;
    assign w_flush     = w_run && bus.flush;
    assign w_kill_clr  = w_flush && (state_q == SLOT_FULL) && writes_reg(rd_we_q, rd_q);

    always_comb begin
        state_d   = state_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        rd_d      = rd_q;
        rd_we_d   = rd_we_q;
        payload_d = payload_q;
        if (w_flush) begin
            state_d = SLOT_EMPTY;
        end else if (w_accept) begin
            state_d   = SLOT_FULL;
            op1_d     = bus.id_use_rs1 ? bus.rdata1 : bus.id_pc;
            op2_d     = bus.id_use_rs2 ? bus.rdata2 : bus.id_imm;
            rd_d      = bus.id_rd;
            rd_we_d   = bus.id_rd_we;
            payload_d = bus.id_payload;
        end else if (w_run && (state_q == SLOT_FULL) && bus.ex_ready) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SLOT_EMPTY;
            op1_q     <= '0;
            op2_q     <= '0;
            rd_q      <= '0;
            rd_we_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            state_q   <= state_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            rd_q      <= rd_d;
            rd_we_q   <= rd_we_d;
            payload_q <= payload_d;
        end
    end

    assign bus.id_ready   = w_id_ready;
    assign bus.re1        = bus.id_valid && bus.id_use_rs1;
    assign bus.re2        = bus.id_valid && bus.id_use_rs2;
    assign bus.raddr1     = bus.id_rs1;
    assign bus.raddr2     = bus.id_rs2;
    assign bus.ex_valid   = (state_q == SLOT_FULL);
    assign bus.ex_op1     = op1_q;
    assign bus.ex_op2     = op2_q;
    assign bus.ex_rd      = rd_q;
    assign bus.ex_rd_we   = rd_we_q;
    assign bus.ex_payload = payload_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module : tb_operand_fetch
// Brief  : Directed scoreboard bench for operand_fetch with a register-file model
// Rev    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] payload;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wb_wdata = '0;
    logic [31:0] rf [32];
    exp_t        exp_q [$];
    int          vectors = 0;
    int          miscompares = 0;

    operand_fetch_if ifc ();

    operand_fetch u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.master)
    );

    always #5 clk = ~clk;

    // Register file: combinational read with write-to-read bypass, x0 reads zero.
    assign ifc.rdata1 = (ifc.raddr1 == 5'd0) ? 32'd0 :
                        (ifc.wb_we && ifc.wb_waddr == ifc.raddr1) ? wb_wdata : rf[ifc.raddr1];
    assign ifc.rdata2 = (ifc.raddr2 == 5'd0) ? 32'd0 :
                        (ifc.wb_we && ifc.wb_waddr == ifc.raddr2) ? wb_wdata : rf[ifc.raddr2];

    function automatic logic [31:0] rf_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (ifc.wb_we && ifc.wb_waddr == a) return wb_wdata;
        return rf[a];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic we,
                         input logic [31:0] tag);
        ifc.id_valid   = 1'b1;
        ifc.id_rs1     = rs1;
        ifc.id_use_rs1 = u1;
        ifc.id_rs2     = rs2;
        ifc.id_use_rs2 = u2;
        ifc.id_rd      = rd;
        ifc.id_rd_we   = we;
        ifc.id_pc      = 32'h8000_0000 | tag;
        ifc.id_imm     = 32'h0000_1000 + tag;
        ifc.id_payload = tag;
    endtask

    task automatic idle();
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0);
        ifc.id_valid = 1'b0;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] a, input logic [31:0] d);
        ifc.wb_we    = we;
        ifc.wb_waddr = a;
        wb_wdata     = d;
    endtask

    // One clock: check at the falling edge, update the expected queue, then advance.
    task automatic cycle(input logic exp_rdy);
        exp_t e;
        @(negedge clk);
        chk("ex_valid", 64'(ifc.ex_valid), 64'(exp_q.size() != 0));
        chk("id_ready", 64'(ifc.id_ready), 64'(exp_rdy));
        chk("re1", 64'(ifc.re1), 64'(ifc.id_valid && ifc.id_use_rs1));
        if (exp_q.size() != 0) begin
            chk("ex_op1", 64'(ifc.ex_op1), 64'(exp_q[0].op1));
            chk("ex_op2", 64'(ifc.ex_op2), 64'(exp_q[0].op2));
            chk("ex_meta", 64'({ifc.ex_rd, ifc.ex_rd_we, ifc.ex_payload}),
                64'({exp_q[0].rd, exp_q[0].rd_we, exp_q[0].payload}));
        end
        if (ifc.rdy) begin
            if (ifc.flush) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end else begin
                if (ifc.ex_ready && exp_q.size() != 0) void'(exp_q.pop_front());
                if (ifc.id_valid && exp_rdy) begin
                    e.op1     = ifc.id_use_rs1 ? rf_rd(ifc.id_rs1) : ifc.id_pc;
                    e.op2     = ifc.id_use_rs2 ? rf_rd(ifc.id_rs2) : ifc.id_imm;
                    e.rd      = ifc.id_rd;
                    e.rd_we   = ifc.id_rd_we;
                    e.payload = ifc.id_payload;
                    exp_q.push_back(e);
                end
            end
        end
        @(posedge clk);
        if (ifc.wb_we && ifc.wb_waddr != 5'd0) rf[ifc.wb_waddr] = wb_wdata;
        #1;
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : 32'h1000 + 32'(i);
        ifc.rdy = 1'b1;
        ifc.flush = 1'b0;
        ifc.ex_ready = 1'b1;
        set_wb(1'b0, 5'd0, 32'd0);
        idle();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_valid", 64'(ifc.ex_valid), 64'd0);
        chk("rst_ex_op1", 64'(ifc.ex_op1), 64'd0);
        chk("rst_ex_op2", 64'(ifc.ex_op2), 64'd0);
        chk("rst_ex_meta", 64'({ifc.ex_rd, ifc.ex_rd_we, ifc.ex_payload}), 64'd0);
        rst = 1'b0;

        // Independent ALU ops back-to-back.
        issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 32'h11); cycle(1'b1);
        issue(5'd3, 1'b1, 5'd4, 1'b1, 5'd8, 1'b1, 32'h12); cycle(1'b1);
        issue(5'd5, 1'b1, 5'd6, 1'b1, 5'd9, 1'b1, 32'h13); cycle(1'b1);
        idle(); set_wb(1'b1, 5'd7, 32'h77); cycle(1'b1);
        set_wb(1'b1, 5'd8, 32'h88); cycle(1'b1);
        set_wb(1'b1, 5'd9, 32'h99); cycle(1'b1);
        set_wb(1'b0, 5'd0, 32'd0);

        // RAW on x5: stall until the producer's writeback, operand via bypass.
        issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 32'h21); cycle(1'b1);
        issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 32'h22); cycle(1'b0);
        cycle(1'b0);
        set_wb(1'b1, 5'd5, 32'hDEAD); cycle(1'b1);
        chk("raw_bypass_op1", 64'(ifc.ex_op1), 64'h0000_DEAD);
        idle(); set_wb(1'b0, 5'd0, 32'd0); cycle(1'b1);

        // WAW on x3: second writer waits, then keeps x3 busy.
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 32'h31); cycle(1'b1);
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 32'h32); cycle(1'b0);
        cycle(1'b0);
        set_wb(1'b1, 5'd3, 32'h333); cycle(1'b1);
        set_wb(1'b0, 5'd0, 32'd0);
        issue(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h33); cycle(1'b0);
        set_wb(1'b1, 5'd3, 32'h3333); cycle(1'b1);
        idle(); set_wb(1'b1, 5'd11, 32'hBB); cycle(1'b1);
        set_wb(1'b0, 5'd0, 32'd0);

        // Backpressure: slot held stable, next op accepted when ex_ready returns.
        ifc.ex_ready = 1'b0;
        issue(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h41); cycle(1'b1);
        issue(5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h42);
        repeat (4) cycle(1'b0);
        ifc.ex_ready = 1'b1; cycle(1'b1);
        idle(); cycle(1'b1);

        // Flush kills the slot and frees x10.
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 32'h51); cycle(1'b1);
        idle(); ifc.ex_ready = 1'b0; ifc.flush = 1'b1; cycle(1'b0);
        ifc.flush = 1'b0; ifc.ex_ready = 1'b1;
        issue(5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h52); cycle(1'b1);
        issue(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h53); ifc.flush = 1'b1; cycle(1'b1);
        ifc.flush = 1'b0; idle(); cycle(1'b1);

        // x0 destination and source never stall.
        issue(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 32'h61); cycle(1'b1);
        chk("x0_op1", 64'(ifc.ex_op1), 64'd0);
        cycle(1'b1);
        idle(); cycle(1'b1);

        // rdy low freezes everything.
        issue(5'd1, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 32'h71); cycle(1'b1);
        issue(5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h72); ifc.rdy = 1'b0;
        cycle(1'b0);
        cycle(1'b0);
        ifc.rdy = 1'b1; cycle(1'b1);
        idle(); cycle(1'b1);

        // Asynchronous reset during a stall.
        ifc.ex_ready = 1'b0;
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, 32'h81); cycle(1'b1);
        issue(5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h82); cycle(1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_ex_valid", 64'(ifc.ex_valid), 64'd0);
        chk("arst_ex_meta", 64'({ifc.ex_rd, ifc.ex_rd_we, ifc.ex_payload}), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        ifc.ex_ready = 1'b1;
        cycle(1'b1);
        issue(5'd14, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h83); cycle(1'b1);
        idle(); cycle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/operand_fetch.md
# operand_fetch

Initiator side of the register file's read ports. Sits between decode and execute: it takes one decoded instruction per cycle, drives the register file read addresses, and checks a per-register busy scoreboard for RAW/WAW hazards. It latches resolved operands into a one-entry output slot with a valid/ready handshake to execute. It observes the register file write port so a register being written this cycle counts as ready, relying on the register file's write-to-read bypass.

## Interface
Parameters:
- XLEN, 32, data width
- REG_ADDR_W, 5, register index width (32 registers; x0 hardwired zero)
- PAYLOAD_W, 32, opaque decoded-op bits passed through to execute

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rdy  in  1  global enable; low freezes all state
- flush  in  1  kill output slot (branch redirect)
- id_valid  in  1  decode presents an instruction
- id_ready  out  1  instruction accepted this cycle when id_valid && id_ready
- id_rs1, id_rs2  in  REG_ADDR_W  source indices
- id_use_rs1, id_use_rs2  in  1  source actually read
- id_rd  in  REG_ADDR_W  destination index
- id_rd_we  in  1  instruction writes rd
- id_pc, id_imm  in  XLEN  alternate operands
- id_payload  in  PAYLOAD_W  pass-through
- re1, re2  out  1  register file read enables
- raddr1, raddr2  out  REG_ADDR_W  register file read addresses
- rdata1, rdata2  in  XLEN  register file read data (combinational, same cycle)
- wb_we  in  1  register file write enable (observed)
- wb_waddr  in  REG_ADDR_W  register file write address (observed)
- ex_valid  out  1  output slot full
- ex_ready  in  1  execute consumes slot
- ex_op1, ex_op2  out  XLEN  resolved operands
- ex_rd  out  REG_ADDR_W, ex_rd_we  out  1, ex_payload  out  PAYLOAD_W  pass-through

## Operation
- Read ports (combinational): re1 = id_valid && id_use_rs1; raddr1 = id_rs1. Port 2 is identical with rs2.
- Scoreboard: busy[1..31]; busy[0] is constantly 0.
  - clr[r] = wb_we && wb_waddr==r.
  - Effective busy is eff[r] = busy[r] && !clr[r].
- Hazard: hz = (use_rs1 && eff[rs1]) || (use_rs2 && eff[rs2]) || (rd_we && rd!=0 && eff[rd]). The WAW check keeps at most one in-flight writer per register.
- id_ready = rdy && !hz && (!ex_valid || ex_ready).
  - id_ready is independent of id_valid except through hz.
  - Flush does not gate id_ready.
- Accept (id_valid && id_ready):
  - Slot loads op1 = use_rs1 ? rdata1 : id_pc and op2 = use_rs2 ? rdata2 : id_imm.
  - Slot loads rd, rd_we, payload.
  - ex_valid <= 1.
  - If rd_we && rd!=0, set busy[rd].
- Slot drain: if ex_valid && ex_ready and no accept, ex_valid <= 0.
- Scoreboard update order per cycle: clear from wb, then set from accept. Set wins on the same index.
- Flush (rdy high):
  - ex_valid <= 0 and no accept that cycle.
  - If the killed slot had rd_we && rd!=0, clear busy[ex_rd].
  - Instructions already past execute are never flushed and always retire through wb.
- rdy low: no state changes, id_ready = 0, outputs held.
- Slot states: EMPTY (ex_valid=0) and FULL (ex_valid=1).
  - EMPTY -> FULL on accept.
  - FULL -> FULL on accept with ex_ready.
  - FULL -> EMPTY on ex_ready without accept, or on flush.

## Timing
- Reset (async assert): ex_valid=0, busy all 0, ex_op1/ex_op2/ex_rd/ex_payload=0, ex_rd_we=0.
- Latency: accept in cycle N gives ex_valid=1 with operands in cycle N+1.
- Throughput is 1 per cycle when hazard-free and ex_ready stays high.
- A wb write to rsX in the same cycle as the dependent instruction presents does not stall. The operand comes from the register file bypass in that cycle.
- A dependent instruction stalls until the cycle its producer's wb_we appears. The earliest accept is that cycle.
- Slot outputs are stable while ex_valid && !ex_ready (no flush).

## Structure
- Shared package: XLEN, REG_ADDR_W, the x0 index constant, and the enable-level constants the register file already uses.
- Natural sub-module: operand_scoreboard. It holds the busy vector, set/clear ports, and eff-busy lookup for three indices.
- The slot register and handshake live in operand_fetch.

## Test plan
- Reset, then three independent ALU ops (rs=1,2 / 3,4 / 5,6; rd=7,8,9) with ex_ready=1 -> accepted back-to-back, ex_valid from cycle 1, operands equal preloaded register values.
- Producer rd=5 accepted, then consumer use_rs1=1 rs1=5 -> consumer stalls (id_ready=0) until wb_we=1/wb_waddr=5/wdata=0xDEAD. It is accepted that cycle with ex_op1=0xDEAD next cycle.
- WAW: rd=3 in flight, new instruction rd=3 -> stall; accepted in the wb cycle for x3, and busy[3] remains set afterwards.
- ex_ready=0 for 4 cycles with slot FULL -> id_ready=0, ex_* outputs unchanged. On ex_ready=1, the next instruction is accepted in the same cycle.
- flush with slot holding rd=10 -> ex_valid=0 next cycle, busy[10] cleared. A following reader of x10 is accepted without a wb.
- rd=0 with rd_we=1, use_rs1 rs1=0 -> never stalls, ex_op1=0. rdy=0 mid-stream -> nothing accepted and state frozen. Async rst mid-stall -> ex_valid=0 and busy cleared immediately.
